mem_arbiter: RTL and testbench

Two-master arbiter that shares one single-port synchronous RAM between the multi-cycle RV32I processor (master 0) and a second requester such as a program loader or DMA (master 1). Each master uses the processor's strobe-style memory interface (addr, rstrb, wmask, wdata, rdata), extended with busy/ready handshake outputs. The arbiter captures strobes into per-master request buffers and grants them round-robin. It sequences each granted access through a fixed-latency RAM.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_req_buf.sv | 72 +++++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-master RAM arbiter.
package mem_arb_pkg;

  // Access sequencing states of the arbiter FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Master indices: the processor and the auxiliary requester (loader/DMA).
  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  // Widest byte mask the helper accepts; narrower masks are zero-extended.
  localparam int MASK_MAX_W = 64;

  // A nonzero byte mask marks the strobe as a write.
  function automatic logic is_write(input logic [MASK_MAX_W-1:0] wmask);
    return |wmask;
  endfunction

endpackage

// File: rtl/mem_arb_req_buf.sv
// Per-master request buffer: captures a strobe, holds it pending until the
// arbiter completes it, and flags strobes that arrive while still pending.
module mem_arb_req_buf
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_rstrb,
  input  logic [DATA_W/8-1:0] i_wmask,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic                i_clr,
  output logic                o_pend,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W/8-1:0] o_wmask,
  output logic [DATA_W-1:0]   o_wdata,
  output logic                o_is_write,
  output logic                o_proto_err
);

  logic                r_pend;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W/8-1:0] r_wmask;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_write;
  logic                r_proto_err;

  logic w_is_wr;
  logic w_strobe;
  logic w_accept;

  assign w_is_wr  = is_write(MASK_MAX_W'(i_wmask));
  assign w_strobe = i_rstrb | w_is_wr;
  // The completion cycle frees the buffer, so a strobe there is accepted.
  assign w_accept = w_strobe & (~r_pend | i_clr);

  // Capture accepted strobes; a new request wins over the completion clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend      <= 1'b0;
      r_addr      <= '0;
      r_wmask     <= '0;
      r_wdata     <= '0;
      r_is_write  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend     <= 1'b1;
        r_addr     <= i_addr;
        r_wmask    <= i_wmask;
        r_wdata    <= i_wdata;
        r_is_write <= w_is_wr;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
      if (w_strobe && r_pend && !i_clr) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign o_pend      = r_pend;
  assign o_addr      = r_addr;
  assign o_wmask     = r_wmask;
  assign o_wdata     = r_wdata;
  assign o_is_write  = r_is_write;
  assign o_proto_err = r_proto_err;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port RAM between the
// processor (master 0) and an auxiliary requester (master 1).
// Handshake: a master issues a single-cycle strobe (rstrb or nonzero wmask);
// busy stays high while the request is pending and ready pulses for exactly
// one cycle when it completes, with read data valid in that same cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_rstrb_i,
  input  logic [DATA_W/8-1:0] m0_wmask_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_busy_o,
  output logic                m0_ready_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_rstrb_i,
  input  logic [DATA_W/8-1:0] m1_wmask_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_busy_o,
  output logic                m1_ready_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic                s_rstrb_o,
  output logic [DATA_W/8-1:0] s_wmask_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                proto_err_o,
  output state_t              dbg_state_o
);

  localparam int MW = DATA_W / 8;

  state_t              r_state;
  logic                r_gnt;
  logic                r_last_gnt;
  logic [2:0]          r_cnt;
  logic [ADDR_W-1:0]   r_s_addr;
  logic                r_s_rstrb;
  logic [MW-1:0]       r_s_wmask;
  logic [DATA_W-1:0]   r_s_wdata;
  logic [DATA_W-1:0]   r_rdata [2];
  logic                r_ready [2];

  logic                w_pend  [2];
  logic [ADDR_W-1:0]   w_addr  [2];
  logic [MW-1:0]       w_wmask [2];
  logic [DATA_W-1:0]   w_wdata [2];
  logic                w_is_wr [2];
  logic                w_perr  [2];
  logic                w_clr   [2];
  logic                w_sel;
  logic                w_tie;

  assign w_clr[0] = (r_state == DONE) && (r_gnt == M_CPU);
  assign w_clr[1] = (r_state == DONE) && (r_gnt == M_AUX);

  mem_arb_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_cpu (
    .i_clk(clk_i), .i_rst_n(rst_ni),
    .i_addr(m0_addr_i), .i_rstrb(m0_rstrb_i), .i_wmask(m0_wmask_i), .i_wdata(m0_wdata_i),
    .i_clr(w_clr[0]),
    .o_pend(w_pend[0]), .o_addr(w_addr[0]), .o_wmask(w_wmask[0]), .o_wdata(w_wdata[0]),
    .o_is_write(w_is_wr[0]), .o_proto_err(w_perr[0])
  );

  mem_arb_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_aux (
    .i_clk(clk_i), .i_rst_n(rst_ni),
    .i_addr(m1_addr_i), .i_rstrb(m1_rstrb_i), .i_wmask(m1_wmask_i), .i_wdata(m1_wdata_i),
    .i_clr(w_clr[1]),
    .o_pend(w_pend[1]), .o_addr(w_addr[1]), .o_wmask(w_wmask[1]), .o_wdata(w_wdata[1]),
    .o_is_write(w_is_wr[1]), .o_proto_err(w_perr[1])
  );

  // Round-robin only rotates on a tie; a lone requester is simply served.
  assign w_tie = w_pend[0] & w_pend[1];
  assign w_sel = w_tie ? ~r_last_gnt : (w_pend[1] ? M_AUX : M_CPU);

  // Access sequencer: grant, drive the RAM for one cycle, wait out the read
  // latency, then pulse ready for the granted master.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_gnt      <= M_CPU;
      r_last_gnt <= M_AUX;
      r_cnt      <= '0;
      r_s_addr   <= '0;
      r_s_rstrb  <= 1'b0;
      r_s_wmask  <= '0;
      r_s_wdata  <= '0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
      r_ready[0] <= 1'b0;
      r_ready[1] <= 1'b0;
    end else begin
      r_s_addr   <= '0;
      r_s_rstrb  <= 1'b0;
      r_s_wmask  <= '0;
      r_s_wdata  <= '0;
      r_ready[0] <= 1'b0;
      r_ready[1] <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pend[0] || w_pend[1]) begin
            r_gnt <= w_sel;
            if (w_tie) r_last_gnt <= w_sel;
            r_s_addr  <= w_addr[w_sel];
            r_s_wdata <= w_wdata[w_sel];
            r_s_wmask <= w_is_wr[w_sel] ? w_wmask[w_sel] : '0;
            r_s_rstrb <= ~w_is_wr[w_sel];
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_is_wr[r_gnt]) begin
            r_ready[r_gnt] <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_cnt   <= 3'(RD_LATENCY);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd1) begin
            r_rdata[r_gnt] <= s_rdata_i;
            r_ready[r_gnt] <= 1'b1;
            r_state        <= DONE;
          end
          r_cnt <= r_cnt - 3'd1;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_rdata_o  = r_rdata[0];
  assign m1_rdata_o  = r_rdata[1];
  assign m0_busy_o   = w_pend[0];
  assign m1_busy_o   = w_pend[1];
  assign m0_ready_o  = r_ready[0];
  assign m1_ready_o  = r_ready[1];
  assign s_addr_o    = r_s_addr;
  assign s_rstrb_o   = r_s_rstrb;
  assign s_wmask_o   = r_s_wmask;
  assign s_wdata_o   = r_s_wdata;
  assign proto_err_o = w_perr[0] | w_perr[1];
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with a 1-cycle RAM and one
// with a 3-cycle RAM, both fed by the same master stimulus.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Shared master inputs
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_rstrb, m1_rstrb;
  logic [3:0]  m0_wmask, m1_wmask;

  // Instance A outputs (RD_LATENCY=1)
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata, a_s_rdata;
  logic        a_m0_busy, a_m0_ready, a_m1_busy, a_m1_ready, a_s_rstrb, a_perr;
  logic [3:0]  a_s_wmask;
  state_t      a_state;

  // Instance B outputs (RD_LATENCY=3)
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata, b_s_rdata;
  logic        b_m0_busy, b_m0_ready, b_m1_busy, b_m1_ready, b_s_rstrb, b_perr;
  logic [3:0]  b_s_wmask;
  state_t      b_state;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_addr_i(m0_addr), .m0_rstrb_i(m0_rstrb), .m0_wmask_i(m0_wmask), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(a_m0_rdata), .m0_busy_o(a_m0_busy), .m0_ready_o(a_m0_ready),
    .m1_addr_i(m1_addr), .m1_rstrb_i(m1_rstrb), .m1_wmask_i(m1_wmask), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(a_m1_rdata), .m1_busy_o(a_m1_busy), .m1_ready_o(a_m1_ready),
    .s_addr_o(a_s_addr), .s_rstrb_o(a_s_rstrb), .s_wmask_o(a_s_wmask), .s_wdata_o(a_s_wdata),
    .s_rdata_i(a_s_rdata), .proto_err_o(a_perr), .dbg_state_o(a_state)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_addr_i(m0_addr), .m0_rstrb_i(m0_rstrb), .m0_wmask_i(m0_wmask), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(b_m0_rdata), .m0_busy_o(b_m0_busy), .m0_ready_o(b_m0_ready),
    .m1_addr_i(m1_addr), .m1_rstrb_i(m1_rstrb), .m1_wmask_i(m1_wmask), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(b_m1_rdata), .m1_busy_o(b_m1_busy), .m1_ready_o(b_m1_ready),
    .s_addr_o(b_s_addr), .s_rstrb_o(b_s_rstrb), .s_wmask_o(b_s_wmask), .s_wdata_o(b_s_wdata),
    .s_rdata_i(b_s_rdata), .proto_err_o(b_perr), .dbg_state_o(b_state)
  );

  // RAM models: A returns data one cycle after the strobe, B three cycles.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] b_p1, b_p2;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (a_s_wmask[b]) mem_a[a_s_addr[9:2]][b*8 +: 8] <= a_s_wdata[b*8 +: 8];
      if (b_s_wmask[b]) mem_b[b_s_addr[9:2]][b*8 +: 8] <= b_s_wdata[b*8 +: 8];
    end
    if (a_s_rstrb) a_s_rdata <= mem_a[a_s_addr[9:2]];
    b_p1      <= mem_b[b_s_addr[9:2]];
    b_p2      <= b_p1;
    b_s_rdata <= b_p2;
  end

  // Scoreboard counters
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to n cycles later, 1 time unit past the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_rstrb = 1'b0; m0_wmask = 4'h0;
    m1_rstrb = 1'b0; m1_wmask = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[8'h10] = 32'hDEADBEEF; mem_b[8'h10] = 32'hDEADBEEF; // byte addr 0x40
    mem_a[8'h20] = 32'h11223344; mem_b[8'h20] = 32'h11223344; // byte addr 0x80
    a_s_rdata = 32'h0; b_s_rdata = 32'h0; b_p1 = 32'h0; b_p2 = 32'h0;
    m0_addr = 32'h0; m0_wdata = 32'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    idle_inputs();

    // Reset state
    rst_n = 1'b0;
    tick(2);
    chk("rst_m0_ready", 32'(a_m0_ready), 32'd0);
    chk("rst_m0_busy",  32'(a_m0_busy),  32'd0);
    chk("rst_m0_rdata", a_m0_rdata,      32'd0);
    chk("rst_s_rstrb",  32'(a_s_rstrb),  32'd0);
    chk("rst_s_wmask",  32'(a_s_wmask),  32'd0);
    chk("rst_perr",     32'(a_perr),     32'd0);
    chk("rst_state",    32'(a_state),    32'(IDLE));
    rst_n = 1'b1;
    tick();

    // 1. Uncontended m0 read of 0x40, latency 1
    m0_addr = 32'h40; m0_rstrb = 1'b1;
    chk("t1_busy_t0", 32'(a_m0_busy), 32'd0);
    tick(); idle_inputs();
    chk("t1_busy_t1", 32'(a_m0_busy), 32'd1);
    tick();
    chk("t1_s_rstrb_t2", 32'(a_s_rstrb), 32'd1);
    chk("t1_s_addr_t2",  a_s_addr,       32'h40);
    tick();
    chk("t1_s_rstrb_t3", 32'(a_s_rstrb),  32'd0);
    chk("t1_ready_t3",   32'(a_m0_ready), 32'd0);
    tick();
    chk("t1_ready_t4", 32'(a_m0_ready), 32'd1);
    chk("t1_busy_t4",  32'(a_m0_busy),  32'd1);
    chk("t1_rdata_t4", a_m0_rdata,      32'hDEADBEEF);
    tick();
    chk("t1_ready_t5", 32'(a_m0_ready), 32'd0);
    chk("t1_busy_t5",  32'(a_m0_busy),  32'd0);

    // 2. m1 byte write to 0x80 lane 2, then read it back
    m1_addr = 32'h80; m1_wmask = 4'b0100; m1_wdata = 32'h00AB0000;
    tick(); idle_inputs();
    chk("t2_s_wmask_t1", 32'(a_s_wmask), 32'd0);
    tick();
    chk("t2_s_wmask_t2", 32'(a_s_wmask), 32'h4);
    chk("t2_s_wdata_t2", a_s_wdata,      32'h00AB0000);
    chk("t2_s_rstrb_t2", 32'(a_s_rstrb), 32'd0);
    tick();
    chk("t2_s_wmask_t3", 32'(a_s_wmask),  32'd0);
    chk("t2_ready_t3",   32'(a_m1_ready), 32'd1);
    chk("t2_rdata_t3",   a_m1_rdata,      32'd0);
    tick();
    chk("t2_ready_t4", 32'(a_m1_ready), 32'd0);
    m1_addr = 32'h80; m1_rstrb = 1'b1;
    tick(); idle_inputs();
    tick(3);
    chk("t2_rd_ready", 32'(a_m1_ready), 32'd1);
    chk("t2_rd_rdata", a_m1_rdata,      32'h11AB3344);
    tick();

    // 3. Tie: m0 first, then m1; repeated tie: m1 first, then m0
    m0_addr = 32'h40; m0_rstrb = 1'b1;
    m1_addr = 32'h80; m1_rstrb = 1'b1;
    tick(); idle_inputs();
    tick();
    chk("t3_first_rstrb", 32'(a_s_rstrb), 32'd1);
    chk("t3_first_addr",  a_s_addr,       32'h40);
    tick(2);
    chk("t3_m0_ready", 32'(a_m0_ready), 32'd1);
    chk("t3_m1_wait",  32'(a_m1_ready), 32'd0);
    tick();
    chk("t3_idle_gap", 32'(a_s_rstrb), 32'd0);
    chk("t3_m1_busy",  32'(a_m1_busy), 32'd1);
    tick();
    chk("t3_second_rstrb", 32'(a_s_rstrb), 32'd1);
    chk("t3_second_addr",  a_s_addr,       32'h80);
    tick(2);
    chk("t3_m1_ready", 32'(a_m1_ready), 32'd1);
    tick();
    m0_addr = 32'h40; m0_rstrb = 1'b1;
    m1_addr = 32'h80; m1_rstrb = 1'b1;
    tick(); idle_inputs();
    tick();
    chk("t3_rep_first_addr", a_s_addr, 32'h80);
    tick(2);
    chk("t3_rep_m1_ready", 32'(a_m1_ready), 32'd1);
    chk("t3_rep_m0_wait",  32'(a_m0_ready), 32'd0);
    tick(2);
    chk("t3_rep_second_addr", a_s_addr, 32'h40);
    tick(2);
    chk("t3_rep_m0_ready", 32'(a_m0_ready), 32'd1);
    tick();

    // 4. Back-to-back on latency-3 instance: new strobe in the ready cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m0_addr = 32'h40; m0_rstrb = 1'b1;
    tick(); idle_inputs();
    chk("t4_busy_t1", 32'(b_m0_busy), 32'd1);
    tick(4);
    chk("t4_ready_t5", 32'(b_m0_ready), 32'd0);
    tick();
    chk("t4_ready_t6", 32'(b_m0_ready), 32'd1);
    chk("t4_rdata_t6", b_m0_rdata,      32'hDEADBEEF);
    m0_addr = 32'h80; m0_rstrb = 1'b1;
    tick(); idle_inputs();
    chk("t4_busy_t7",  32'(b_m0_busy),  32'd1);
    chk("t4_ready_t7", 32'(b_m0_ready), 32'd0);
    tick(4);
    chk("t4_ready_t11", 32'(b_m0_ready), 32'd0);
    tick();
    chk("t4_ready_t12", 32'(b_m0_ready), 32'd1);
    chk("t4_rdata_t12", b_m0_rdata,      32'h11AB3344);
    chk("t4_perr",      32'(b_perr),     32'd0);
    tick();
    chk("t4_busy_t13", 32'(b_m0_busy), 32'd0);

    // 5. Protocol error: m1 strobes again while pending
    chk("t5_perr_before", 32'(a_perr), 32'd0);
    m1_addr = 32'h80; m1_rstrb = 1'b1;
    tick();
    m1_addr = 32'h40; m1_rstrb = 1'b1;
    tick(); idle_inputs();
    chk("t5_perr_set", 32'(a_perr), 32'd1);
    tick(2);
    chk("t5_ready", 32'(a_m1_ready), 32'd1);
    chk("t5_rdata", a_m1_rdata,      32'h11AB3344);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_extra_ready", 32'(a_m1_ready), 32'd0);
    end
    chk("t5_busy_end", 32'(a_m1_busy), 32'd0);
    chk("t5_perr_hold", 32'(a_perr),   32'd1);

    // 6. Reset during WAIT discards the read
    m0_addr = 32'h40; m0_rstrb = 1'b1;
    tick(); idle_inputs();
    tick(2);
    chk("t6_in_wait", 32'(a_state), 32'(WAIT));
    rst_n = 1'b0;
    tick();
    chk("t6_state", 32'(a_state),    32'(IDLE));
    chk("t6_busy",  32'(a_m0_busy),  32'd0);
    chk("t6_ready", 32'(a_m0_ready), 32'd0);
    chk("t6_rdata", a_m0_rdata,      32'd0);
    chk("t6_perr",  32'(a_perr),     32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_no_late_ready", 32'(a_m0_ready), 32'd0);
    m0_addr = 32'h40; m0_rstrb = 1'b1;
    tick(); idle_inputs();
    tick(3);
    chk("t6_new_ready", 32'(a_m0_ready), 32'd1);
    chk("t6_new_rdata", a_m0_rdata,      32'hDEADBEEF);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
